cfg_frame_parser: RTL and testbench
===================================

// Module: cfg_frame_parser
// PURPOSE
//  Parametrised host-command parser: accepts a byte stream (valid/ready), frames it as
//  SYNC | ADDR | DATA_BYTES data bytes (LSB first) | XOR checksum, and issues one config write
//  (channel, register, data) to the downstream config bus with valid/ready backpressure.
//  Adds sync detection, checksum, channel range check, inter-byte timeout and ack/nack status.
// PARAMETERS
//  DATA_BYTES   4      payload bytes per frame (1..8); cfg_data width = 8*DATA_BYTES
//  NUM_CH       4      config channels (1..16); CH_W = max(1,$clog2(NUM_CH))
//  REG_W        4      register-index bits in ADDR byte; CH_W+REG_W <= 8
//  SYNC_BYTE    8'hA5  frame start marker
//  TIMEOUT_CYC  1024   max clk cycles between accepted bytes inside a frame (>=2)
// PORTS
//  clk           in   1              clock
//  rst_n         in   1              asynchronous, active-low reset
//  pc_cmd_valid  in   1              host byte valid
//  pc_cmd_ready  out  1              parser can accept byte
//  pc_cmd_data   in   8              host byte
//  cfg_valid     out  1              config write pending
//  cfg_ready     in   1              downstream accepts write
//  cfg_ch        out  CH_W           target channel = ADDR[CH_W+REG_W-1:REG_W]
//  cfg_addr      out  REG_W          register index = ADDR[REG_W-1:0]
//  cfg_data      out  8*DATA_BYTES   payload, byte0 in [7:0]
//  pc_ack        out  1              1-cycle pulse: frame accepted downstream
//  pc_nack       out  1              1-cycle pulse: frame dropped
//  err_code      out  2              valid with pc_nack: 1 checksum, 2 bad channel, 3 timeout
// BEHAVIOUR
//  Reset: state IDLE; pc_cmd_ready=1; cfg_valid=0; cfg_ch/cfg_addr/cfg_data=0; pc_ack=pc_nack=0;
//   err_code=0; timer=0. Reset mid-frame discards the partial frame, no ack/nack.
//  Byte accepted when pc_cmd_valid & pc_cmd_ready. pc_cmd_ready = (state != OUT).
//  FSM (transitions on accepted byte unless noted):
//   IDLE: byte==SYNC_BYTE -> ADDR; any other byte discarded silently, stay IDLE.
//   ADDR: store byte, csum<=byte, byte_idx<=0 -> DATA. (SYNC_BYTE value here is a normal ADDR.)
//   DATA: data[byte_idx]<=byte, csum^=byte; byte_idx==DATA_BYTES-1 -> CSUM else byte_idx+1.
//   CSUM: byte!=csum -> nack(1), IDLE; else chan>=NUM_CH -> nack(2), IDLE;
//         else load cfg_* outputs, cfg_valid<=1 -> OUT.
//   OUT:  no bytes taken; on cfg_valid&cfg_ready: cfg_valid<=0, pc_ack pulse, -> IDLE.
//         cfg_ch/addr/data stable while cfg_valid=1. No timeout in OUT (waits indefinitely).
//  Latency: cfg_valid rises the cycle after the checksum byte is accepted; pc_ack the cycle
//   after the cfg handshake; pc_nack the cycle after the offending byte/timeout.
//  Timer: cleared on every accepted byte and in IDLE/OUT; increments each cycle in ADDR/DATA/CSUM
//   without an accepted byte; reaching TIMEOUT_CYC-1 -> nack(3), IDLE, partial frame dropped.
//   A byte accepted in the same cycle the timer expires wins (byte processed, timer cleared).
//  cfg_data bytes not rewritten by the current frame never leak: all DATA_BYTES are written.
//  pc_ack and pc_nack never assert together; err_code holds last value between nacks.
// STRUCTURE
//  Package cfg_parser_pkg: state enum {IDLE,ADDR,DATA,CSUM,OUT}, err codes ERR_NONE/CSUM/
//   CHAN/TIMEOUT, default SYNC_BYTE constant.
//  Sub-module cfg_byte_timer (clear, enable, expire; parameter TIMEOUT_CYC). Rest in top.
// TESTING
//  1 Defaults: A5 13 11 22 33 44 csum=13^11^22^33^44=0x57, cfg_ready=1 -> cfg_ch=1 cfg_addr=3
//    cfg_data=32'h44332211, one cfg_valid cycle, pc_ack 1 cycle later.
//  2 Bad checksum: A5 13 11 22 33 44 00 -> no cfg_valid, pc_nack=1 err_code=1, next frame OK.
//  3 Bad channel (NUM_CH=3): A5 35 00 00 00 00 35 -> pc_nack err_code=2.
//  4 Timeout: A5 13 11 then idle TIMEOUT_CYC cycles -> pc_nack err_code=3; byte on the
//    expiry cycle instead -> no nack, frame continues.
//  5 Backpressure: cfg_ready=0 for 20 cycles -> cfg_valid/data stable, pc_cmd_ready=0,
//    host bytes held; cfg_ready=1 -> ack, stream resumes with no byte lost.
//  6 Garbage + reset: 00 FF 13 before A5 ignored; rst_n low mid-DATA -> all outputs reset values.

Source files
------------

// File: rtl/cfg_parser_pkg.sv
// Shared types and constants for the host command frame parser.
package cfg_parser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        CSUM,
        OUT
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_CHAN    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/cfg_byte_timer.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear and
// flags expiry when the count reaches TIMEOUT_CYC-1.
module cfg_byte_timer #(
    parameter int unsigned TIMEOUT_CYC = 1024,
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count;

    assign expire = enable && (count == CNT_W'(TIMEOUT_CYC - 1));

    // Count idle cycles; restart after a clear or an expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cfg_frame_parser.sv
// Host command parser: frames SYNC | ADDR | DATA_BYTES payload (LSB first) | XOR
// checksum from a byte stream and issues one config write per good frame.
module cfg_frame_parser
    import cfg_parser_pkg::*;
#(
    parameter int unsigned DATA_BYTES  = 4,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned REG_W       = 4,
    parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYC = 1024,
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pc_cmd_valid,
    output logic                    pc_cmd_ready,
    input  logic [7:0]              pc_cmd_data,
    output logic                    cfg_valid,
    input  logic                    cfg_ready,
    output logic [CH_W-1:0]         cfg_ch,
    output logic [REG_W-1:0]        cfg_addr,
    output logic [8*DATA_BYTES-1:0] cfg_data,
    output logic                    pc_ack,
    output logic                    pc_nack,
    output logic [1:0]              err_code
);

    localparam int unsigned IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int unsigned AW    = CH_W + REG_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic                    byte_acc;
    logic                    in_frame;
    logic                    tmr_expire;
    logic [AW-1:0]           addr_q;
    logic [7:0]              csum_q;
    logic [IDX_W-1:0]        byte_idx;
    logic [8*DATA_BYTES-1:0] data_q;
    logic [CH_W-1:0]         chan;
    logic                    chan_bad;
    logic                    ack_nxt;
    logic                    nack_nxt;
    logic                    load_cfg;
    err_t                    err_nxt;

    assign pc_cmd_ready = (state != OUT);
    assign byte_acc     = pc_cmd_valid && pc_cmd_ready;
    assign in_frame     = (state == ADDR) || (state == DATA) || (state == CSUM);
    assign chan         = addr_q[AW-1:REG_W];
    assign chan_bad     = (32'(chan) >= NUM_CH);

    // Expiry is only possible on a cycle without an accepted byte, so a byte
    // arriving on the expiry cycle is processed instead of timing out.
    cfg_byte_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (byte_acc || !in_frame),
        .enable (in_frame && !byte_acc),
        .expire (tmr_expire)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus ack/nack/load strobes.
    always_comb begin
        state_nxt = state;
        ack_nxt   = 1'b0;
        nack_nxt  = 1'b0;
        err_nxt   = ERR_NONE;
        load_cfg  = 1'b0;
        case (state)
            IDLE: begin
                if (byte_acc && (pc_cmd_data == SYNC_BYTE)) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (byte_acc) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (byte_acc && (byte_idx == LAST_IDX)) begin
                    state_nxt = CSUM;
                end
            end
            CSUM: begin
                if (byte_acc) begin
                    if (pc_cmd_data != csum_q) begin
                        nack_nxt  = 1'b1;
                        err_nxt   = ERR_CSUM;
                        state_nxt = IDLE;
                    end else if (chan_bad) begin
                        nack_nxt  = 1'b1;
                        err_nxt   = ERR_CHAN;
                        state_nxt = IDLE;
                    end else begin
                        load_cfg  = 1'b1;
                        state_nxt = OUT;
                    end
                end
            end
            OUT: begin
                if (cfg_valid && cfg_ready) begin
                    ack_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (tmr_expire) begin
            nack_nxt  = 1'b1;
            err_nxt   = ERR_TIMEOUT;
            state_nxt = IDLE;
        end
    end

    // Frame capture: address, running checksum and payload bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            csum_q   <= '0;
            byte_idx <= '0;
            data_q   <= '0;
        end else if (byte_acc) begin
            case (state)
                ADDR: begin
                    addr_q   <= pc_cmd_data[AW-1:0];
                    csum_q   <= pc_cmd_data;
                    byte_idx <= '0;
                end
                DATA: begin
                    csum_q <= csum_q ^ pc_cmd_data;
                    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
                        if (byte_idx == IDX_W'(i)) begin
                            data_q[8*i +: 8] <= pc_cmd_data;
                        end
                    end
                    if (byte_idx != LAST_IDX) begin
                        byte_idx <= byte_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Config write outputs and host status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_valid <= 1'b0;
            cfg_ch    <= '0;
            cfg_addr  <= '0;
            cfg_data  <= '0;
            pc_ack    <= 1'b0;
            pc_nack   <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            pc_ack  <= ack_nxt;
            pc_nack <= nack_nxt;
            if (nack_nxt) begin
                err_code <= err_nxt;
            end
            if (load_cfg) begin
                cfg_valid <= 1'b1;
                cfg_ch    <= chan;
                cfg_addr  <= addr_q[REG_W-1:0];
                cfg_data  <= data_q;
            end else if (cfg_valid && cfg_ready) begin
                cfg_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cfg_frame_parser.sv
// Self-checking bench for cfg_frame_parser: directed frames plus randomized
// traffic, compared every cycle against a byte-queue reference model.
module tb_cfg_frame_parser;

    localparam int unsigned DB   = 4;
    localparam int unsigned NCH  = 3;
    localparam int unsigned RW   = 4;
    localparam int unsigned CHW  = 2;
    localparam int unsigned TO   = 32;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            pc_cmd_valid = 1'b0;
    logic            pc_cmd_ready;
    logic [7:0]      pc_cmd_data = 8'h00;
    logic            cfg_valid;
    logic            cfg_ready = 1'b0;
    logic [CHW-1:0]  cfg_ch;
    logic [RW-1:0]   cfg_addr;
    logic [8*DB-1:0] cfg_data;
    logic            pc_ack;
    logic            pc_nack;
    logic [1:0]      err_code;

    int n_checks = 0;
    int n_errors = 0;
    int rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready

    cfg_frame_parser #(
        .DATA_BYTES (DB),
        .NUM_CH     (NCH),
        .REG_W      (RW),
        .SYNC_BYTE  (SYNC),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_cmd_valid(pc_cmd_valid),
        .pc_cmd_ready(pc_cmd_ready),
        .pc_cmd_data (pc_cmd_data),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .pc_ack      (pc_ack),
        .pc_nack     (pc_nack),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]      frm[$];
    int              idle_cnt;
    logic            m_ready, m_cfg_valid, m_ack, m_nack;
    logic [CHW-1:0]  m_ch;
    logic [RW-1:0]   m_addr;
    logic [8*DB-1:0] m_data;
    logic [1:0]      m_err;

    task automatic mdl_reset();
        frm.delete();
        idle_cnt    = 0;
        m_ready     = 1'b1;
        m_cfg_valid = 1'b0;
        m_ack       = 1'b0;
        m_nack      = 1'b0;
        m_ch        = '0;
        m_addr      = '0;
        m_data      = '0;
        m_err       = 2'd0;
    endtask

    task automatic cmp_all();
        check("ready",     pc_cmd_ready, m_ready);
        check("cfg_valid", cfg_valid,    m_cfg_valid);
        check("cfg_ch",    cfg_ch,       m_ch);
        check("cfg_addr",  cfg_addr,     m_addr);
        check("cfg_data",  cfg_data,     m_data);
        check("ack",       pc_ack,       m_ack);
        check("nack",      pc_nack,      m_nack);
        check("err_code",  err_code,     m_err);
        check("ack_nack_excl", pc_ack & pc_nack, 1'b0);
    endtask

    // Compare this cycle's outputs, then advance the model across the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mdl_reset();
            cmp_all();
        end else begin
            logic       n_ack, n_nack;
            logic [7:0] x;
            int         chan;
            cmp_all();
            n_ack  = 1'b0;
            n_nack = 1'b0;
            if (m_cfg_valid) begin
                if (cfg_ready) begin
                    m_cfg_valid = 1'b0;
                    n_ack       = 1'b1;
                end
            end else if (pc_cmd_valid && m_ready) begin
                idle_cnt = 0;
                if (frm.size() != 0 || pc_cmd_data == SYNC) frm.push_back(pc_cmd_data);
                if (frm.size() == DB + 3) begin
                    x = 8'h00;
                    for (int i = 1; i <= DB + 1; i++) x ^= frm[i];
                    chan = (int'(frm[1]) >> RW) % (1 << CHW);
                    if (frm[DB+2] != x) begin
                        n_nack = 1'b1;
                        m_err  = 2'd1;
                    end else if (chan >= NCH) begin
                        n_nack = 1'b1;
                        m_err  = 2'd2;
                    end else begin
                        m_cfg_valid = 1'b1;
                        m_ch        = CHW'(chan);
                        m_addr      = RW'(int'(frm[1]) % (1 << RW));
                        for (int i = 0; i < DB; i++) m_data[8*i +: 8] = frm[2+i];
                    end
                    frm.delete();
                end
            end else if (frm.size() != 0) begin
                idle_cnt++;
                if (idle_cnt == TO) begin
                    n_nack = 1'b1;
                    m_err  = 2'd3;
                    frm.delete();
                    idle_cnt = 0;
                end
            end
            m_ack   = n_ack;
            m_nack  = n_nack;
            m_ready = !m_cfg_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       cfg_ready = ($urandom_range(0, 3) != 0);
                1:       cfg_ready = 1'b1;
                default: cfg_ready = 1'b0;
            endcase
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        pc_cmd_valid = 1'b1;
        pc_cmd_data  = b;
        @(negedge clk);
        while (!pc_cmd_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!pc_cmd_ready) check("send_stall", 64'(waited), 0);
        @(posedge clk);
        #1;
        pc_cmd_valid = 1'b0;
        pc_cmd_data  = 8'($urandom);
    endtask

    function automatic logic [7:0] csum_of(input logic [7:0] a, input logic [31:0] d);
        return a ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
    endfunction

    task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] cx);
        logic [7:0] c;
        c = csum_of(a, d) ^ cx;
        send_byte(SYNC);
        send_byte(a);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
        send_byte(c);
    endtask

    task automatic expect_write(input logic [CHW-1:0] ch, input logic [RW-1:0] ad, input logic [31:0] d);
        @(negedge clk);
        check("wr_valid", cfg_valid, 1'b1);
        check("wr_ch",    cfg_ch,    ch);
        check("wr_addr",  cfg_addr,  ad);
        check("wr_data",  cfg_data,  d);
        check("wr_noack", pc_ack,    1'b0);
        @(negedge clk);
        check("wr_once",  cfg_valid, 1'b0);
        check("wr_ack",   pc_ack,    1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_nack(input logic [1:0] code);
        @(negedge clk);
        check("nk_pulse", pc_nack,   1'b1);
        check("nk_code",  err_code,  code);
        check("nk_noval", cfg_valid, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Global bound so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0]  fb[$];
        logic [7:0]  a;
        logic [31:0] d;
        int          mode, cut;

        mdl_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", pc_cmd_ready, 1'b1);
        check("rst_valid", cfg_valid,    1'b0);
        check("rst_data",  cfg_data,     32'h0);
        check("rst_nack",  pc_nack,      1'b0);
        check("rst_err",   err_code,     2'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Basic frame
        rdy_mode = 1;
        send_frame(8'h13, 32'h44332211, 8'h00);
        expect_write(2'd1, 4'd3, 32'h44332211);

        // Bad checksum, then a good frame
        send_frame(8'h13, 32'h44332211, 8'h57);
        expect_nack(2'd1);
        send_frame(8'h13, 32'h44332211, 8'h00);
        expect_write(2'd1, 4'd3, 32'h44332211);

        // Channel 3 out of range
        send_frame(8'h35, 32'h0, 8'h00);
        expect_nack(2'd2);

        // Timeout mid-frame
        send_byte(SYNC);
        send_byte(8'h13);
        send_byte(8'h11);
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            check("to_early", pc_nack, 1'b0);
        end
        @(negedge clk);
        check("to_nack", pc_nack,  1'b1);
        check("to_err",  err_code, 2'd3);
        @(posedge clk);
        #1;

        // Byte arriving on the expiry cycle keeps the frame alive
        send_byte(SYNC);
        send_byte(8'h13);
        send_byte(8'h11);
        idle(TO - 1);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h57);
        expect_write(2'd1, 4'd3, 32'h44332211);

        // Backpressure with the next frame queued behind it
        rdy_mode = 2;
        send_frame(8'h21, 32'hDEADBEEF, 8'h00);
        fork
            send_frame(8'h13, 32'h44332211, 8'h00);
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    check("bp_valid", cfg_valid,    1'b1);
                    check("bp_data",  cfg_data,     32'hDEADBEEF);
                    check("bp_ch",    cfg_ch,       2'd2);
                    check("bp_addr",  cfg_addr,     4'd1);
                    check("bp_ready", pc_cmd_ready, 1'b0);
                end
                @(posedge clk);
                #1;
                rdy_mode = 1;
            end
        join
        expect_write(2'd1, 4'd3, 32'h44332211);

        // Leading garbage is ignored
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        send_frame(8'h13, 32'h44332211, 8'h00);
        expect_write(2'd1, 4'd3, 32'h44332211);

        // Reset in the middle of the payload
        send_byte(SYNC);
        send_byte(8'h13);
        send_byte(8'h11);
        send_byte(8'h22);
        rst_n = 1'b0;
        #1;
        check("mr_ready", pc_cmd_ready, 1'b1);
        check("mr_valid", cfg_valid,    1'b0);
        check("mr_ch",    cfg_ch,       2'd0);
        check("mr_addr",  cfg_addr,     4'd0);
        check("mr_data",  cfg_data,     32'h0);
        check("mr_ack",   pc_ack,       1'b0);
        check("mr_nack",  pc_nack,      1'b0);
        check("mr_err",   err_code,     2'd0);
        idle(2);
        rst_n = 1'b1;
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h57);
        send_frame(8'h13, 32'h44332211, 8'h00);
        expect_write(2'd1, 4'd3, 32'h44332211);

        // Randomized traffic against the model
        rdy_mode = 0;
        for (int f = 0; f < 250; f++) begin
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    a = 8'($urandom);
                    if (a == SYNC) a = 8'h00;
                    send_byte(a);
                end
            end
            a = 8'($urandom);
            d = $urandom;
            fb.delete();
            fb.push_back(SYNC);
            fb.push_back(a);
            for (int i = 0; i < 4; i++) fb.push_back(d[8*i +: 8]);
            fb.push_back(csum_of(a, d) ^ (($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00));
            mode = $urandom_range(0, 29);
            cut  = $urandom_range(0, DB + 1);
            for (int k = 0; k < fb.size(); k++) begin
                send_byte(fb[k]);
                if (mode == 0 && k == cut) begin
                    idle(TO + $urandom_range(0, 4));
                    break;
                end
                if (mode == 1 && k == cut) idle(TO - 1);
                else if (k < fb.size() - 1) idle($urandom_range(0, 2));
            end
            idle($urandom_range(0, 3));
        end
        rdy_mode = 1;
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
